mem_sweep_checker: RTL and testbench



---
 rtl/mem_sweep_checker_if.sv | 19 +
 rtl/mem_sweep_checker.sv | 259 +++++++++++++++++++++++++
 tb/tb_mem_sweep_checker.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sweep_checker_if.sv
// Data-RAM read port shared between the CPU bench and the post-run checker.
// The checker drives the read strobe and address; the RAM returns read data.
interface mem_sweep_checker_if;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_readdata;

  modport master (
    output mem_read,
    output mem_address,
    input  mem_readdata
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    output mem_readdata
  );
endinterface

// File: rtl/mem_sweep_checker.sv
// Post-run data-memory checker. Once armed, it waits for the CPU to go idle and
// then sweeps each configured region, comparing every word against
// exp_start + idx*exp_step (built incrementally). It reports pass/fail, a
// saturating error count and the first mismatching address/data.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | after reset, nothing armed
//   WAIT_CPU | armed, waiting for cpu_active to drop; timeout down-counter runs
//   SWEEP    | reading and comparing words, region by region
//   DONE     | results held until the next start or reset
module mem_sweep_checker #(
  parameter int N_REGIONS      = 2,
  parameter int READ_LATENCY   = 0,
  parameter int SWAP_ENDIAN    = 1,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic                     cpu_active_i,
  input  logic [32*N_REGIONS-1:0]  cfg_base_i,
  input  logic [16*N_REGIONS-1:0]  cfg_count_i,
  input  logic [32*N_REGIONS-1:0]  cfg_exp_start_i,
  input  logic [32*N_REGIONS-1:0]  cfg_exp_step_i,
  mem_sweep_checker_if.master      mem,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [15:0]              error_count_o,
  output logic [31:0]              first_err_addr_o,
  output logic [31:0]              first_err_data_o
);

  localparam int RW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_CPU, S_SWEEP, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [32*N_REGIONS-1:0]   base_q, base_d;
  logic [16*N_REGIONS-1:0]   count_q, count_d;
  logic [32*N_REGIONS-1:0]   exp_start_q, exp_start_d;
  logic [32*N_REGIONS-1:0]   step_q, step_d;
  logic [RW-1:0]             region_q, region_d;
  logic [15:0]               left_q, left_d;
  logic [31:0]               addr_q, addr_d;
  logic [31:0]               exp_q, exp_d;
  logic [31:0]               cur_step_q, cur_step_d;
  logic                      phase_q, phase_d;
  logic [31:0]               tmr_q, tmr_d;
  logic                      done_q, done_d;
  logic                      pass_q, pass_d;
  logic                      timeout_q, timeout_d;
  logic [15:0]               err_q, err_d;
  logic [31:0]               fea_q, fea_d;
  logic [31:0]               fed_q, fed_d;

  logic                      first_hit, next_hit;
  logic [RW-1:0]             first_idx, next_idx, ld_idx;
  logic [31:0]               ld_base, ld_exp, ld_step;
  logic [15:0]               ld_count;
  logic [31:0]               rd_raw, rd_data;
  logic                      cmp_en, mismatch;

  assign rd_raw  = mem.mem_readdata;
  assign rd_data = (SWAP_ENDIAN != 0) ?
                   {rd_raw[7:0], rd_raw[15:8], rd_raw[23:16], rd_raw[31:24]} : rd_raw;

  // With registered RAM the address is held two cycles and compared on the second.
  assign cmp_en   = (state_q == S_SWEEP) && ((READ_LATENCY == 0) || phase_q);
  assign mismatch = (rd_data != exp_q);

  // Lowest non-empty region overall, and lowest non-empty region after the current one.
  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    next_hit  = 1'b0;
    next_idx  = '0;
    for (int j = N_REGIONS - 1; j >= 0; j--) begin
      if (count_q[16*j +: 16] != 16'd0) begin
        first_hit = 1'b1;
        first_idx = RW'(j);
        if (j > int'(region_q)) begin
          next_hit = 1'b1;
          next_idx = RW'(j);
        end
      end
    end
  end

  // Fields of the region about to be entered.
  always_comb begin
    ld_idx   = (state_q == S_WAIT_CPU) ? first_idx : next_idx;
    ld_base  = '0;
    ld_exp   = '0;
    ld_step  = '0;
    ld_count = '0;
    for (int j = 0; j < N_REGIONS; j++) begin
      if (RW'(j) == ld_idx) begin
        ld_base  = base_q[32*j +: 32];
        ld_exp   = exp_start_q[32*j +: 32];
        ld_step  = step_q[32*j +: 32];
        ld_count = count_q[16*j +: 16];
      end
    end
  end

  // Next-state logic: arming, CPU wait with timeout, sweep and result capture.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    exp_start_d = exp_start_q;
    step_d      = step_q;
    region_d    = region_q;
    left_d      = left_q;
    addr_d      = addr_q;
    exp_d       = exp_q;
    cur_step_d  = cur_step_q;
    phase_d     = phase_q;
    tmr_d       = tmr_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    fea_d       = fea_q;
    fed_d       = fed_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          base_d      = cfg_base_i;
          count_d     = cfg_count_i;
          exp_start_d = cfg_exp_start_i;
          step_d      = cfg_exp_step_i;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          err_d       = '0;
          fea_d       = '0;
          fed_d       = '0;
          tmr_d       = 32'(TIMEOUT_CYCLES);
          state_d     = S_WAIT_CPU;
        end
      end

      S_WAIT_CPU: begin
        if (!cpu_active_i) begin
          if (first_hit) begin
            region_d   = first_idx;
            left_d     = ld_count;
            addr_d     = ld_base;
            exp_d      = ld_exp;
            cur_step_d = ld_step;
            phase_d    = 1'b0;
            state_d    = S_SWEEP;
          end else begin
            // Every region empty: nothing to sweep, trivially passing.
            done_d  = 1'b1;
            pass_d  = (err_q == 16'd0);
            state_d = S_DONE;
          end
        end else if (tmr_q <= 32'd1) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end

      S_SWEEP: begin
        if (READ_LATENCY != 0) phase_d = ~phase_q;
        if (cmp_en) begin
          if (mismatch) begin
            if (err_q == 16'd0) begin
              fea_d = addr_q;
              fed_d = rd_data;
            end
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          end
          if (left_q > 16'd1) begin
            left_d = left_q - 16'd1;
            addr_d = addr_q + 32'd4;
            exp_d  = exp_q + cur_step_q;
          end else if (next_hit) begin
            region_d   = next_idx;
            left_d     = ld_count;
            addr_d     = ld_base;
            exp_d      = ld_exp;
            cur_step_d = ld_step;
          end else begin
            done_d  = 1'b1;
            pass_d  = (err_d == 16'd0) && !timeout_q;
            state_d = S_DONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      exp_start_q <= '0;
      step_q      <= '0;
      region_q    <= '0;
      left_q      <= '0;
      addr_q      <= '0;
      exp_q       <= '0;
      cur_step_q  <= '0;
      phase_q     <= 1'b0;
      tmr_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= '0;
      fea_q       <= '0;
      fed_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      exp_start_q <= exp_start_d;
      step_q      <= step_d;
      region_q    <= region_d;
      left_q      <= left_d;
      addr_q      <= addr_d;
      exp_q       <= exp_d;
      cur_step_q  <= cur_step_d;
      phase_q     <= phase_d;
      tmr_q       <= tmr_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      fea_q       <= fea_d;
      fed_q       <= fed_d;
    end
  end

  assign mem.mem_read    = (state_q == S_SWEEP);
  assign mem.mem_address = (state_q == S_SWEEP) ? addr_q : 32'd0;
  assign busy_o           = (state_q == S_WAIT_CPU) || (state_q == S_SWEEP);
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign timeout_o        = timeout_q;
  assign error_count_o    = err_q;
  assign first_err_addr_o = fea_q;
  assign first_err_data_o = fed_q;

endmodule

// File: tb/tb_mem_sweep_checker.sv
// Bench for mem_sweep_checker. Two instances: A uses a combinational RAM with
// byte swapping, B a registered RAM without swapping. Stimulus pushes expected
// read addresses and final results into queues; monitors pop and compare.
module tb_mem_sweep_checker;

  typedef struct {
    logic        p;
    logic        t;
    logic [15:0] e;
    logic [31:0] fa;
    logic [31:0] fd;
    int          rd;
    int          busy;
    logic [31:0] last;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        reset_a, start_a, cpu_a, busy_a, done_a, pass_a, tmo_a;
  logic [63:0] base_a, es_a, st_a;
  logic [31:0] cnt_a;
  logic [15:0] err_a;
  logic [31:0] fea_a, fed_a;

  logic        reset_b, start_b, cpu_b, busy_b, done_b, pass_b, tmo_b;
  logic [63:0] base_b, es_b, st_b;
  logic [31:0] cnt_b;
  logic [15:0] err_b;
  logic [31:0] fea_b, fed_b;

  logic [31:0] ram_a [0:255];
  logic [31:0] ram_b [0:255];
  logic [31:0] rd_b_q;

  mem_sweep_checker_if bus_a ();
  mem_sweep_checker_if bus_b ();

  assign bus_a.mem_readdata = ram_a[bus_a.mem_address[9:2]];
  always @(posedge clk) rd_b_q <= ram_b[bus_b.mem_address[9:2]];
  assign bus_b.mem_readdata = rd_b_q;

  mem_sweep_checker #(.N_REGIONS(2), .READ_LATENCY(0), .SWAP_ENDIAN(1), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .reset(reset_a), .start_i(start_a), .cpu_active_i(cpu_a),
    .cfg_base_i(base_a), .cfg_count_i(cnt_a), .cfg_exp_start_i(es_a), .cfg_exp_step_i(st_a),
    .mem(bus_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .timeout_o(tmo_a),
    .error_count_o(err_a), .first_err_addr_o(fea_a), .first_err_data_o(fed_a));

  mem_sweep_checker #(.N_REGIONS(2), .READ_LATENCY(1), .SWAP_ENDIAN(0), .TIMEOUT_CYCLES(100)) dut_b (
    .clk(clk), .reset(reset_b), .start_i(start_b), .cpu_active_i(cpu_b),
    .cfg_base_i(base_b), .cfg_count_i(cnt_b), .cfg_exp_start_i(es_b), .cfg_exp_step_i(st_b),
    .mem(bus_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .timeout_o(tmo_b),
    .error_count_o(err_b), .first_err_addr_o(fea_b), .first_err_data_o(fed_b));

  logic [31:0] addr_q_a [$];
  logic [31:0] addr_q_b [$];
  res_t        res_q_a [$];
  res_t        res_q_b [$];

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t r, input logic p, input logic t,
                           input logic [15:0] e, input logic [31:0] fa, input logic [31:0] fd,
                           input int rd, input int busy, input logic [31:0] last);
    cmp({tag, "_pass"}, p, r.p);
    cmp({tag, "_timeout"}, t, r.t);
    cmp({tag, "_errcnt"}, e, r.e);
    cmp({tag, "_first_addr"}, fa, r.fa);
    cmp({tag, "_first_data"}, fd, r.fd);
    cmp({tag, "_reads"}, rd, r.rd);
    cmp({tag, "_busy_cycles"}, busy, r.busy);
    cmp({tag, "_last_addr"}, last, r.last);
  endtask

  // Monitor A
  int          rd_cnt_a = 0, busy_cnt_a = 0;
  logic [31:0] last_a = '0;
  logic        done_prev_a = 1'b0;
  always @(negedge clk) begin
    if (bus_a.mem_read) begin
      rd_cnt_a++;
      last_a = bus_a.mem_address;
      if (addr_q_a.size() == 0) cmp("a_unexpected_read", bus_a.mem_address, 32'hFFFF_FFFF);
      else cmp("a_addr", bus_a.mem_address, addr_q_a.pop_front());
    end
    if (busy_a) busy_cnt_a++;
    if (done_a && !done_prev_a) begin
      if (res_q_a.size() == 0) cmp("a_unexpected_done", 32'd1, 32'd0);
      else check_res("a", res_q_a.pop_front(), pass_a, tmo_a, err_a, fea_a, fed_a,
                     rd_cnt_a, busy_cnt_a, last_a);
      rd_cnt_a = 0; busy_cnt_a = 0; last_a = '0;
    end
    if (reset_a) begin
      rd_cnt_a = 0; busy_cnt_a = 0; last_a = '0;
    end
    done_prev_a = done_a;
  end

  // Monitor B
  int          rd_cnt_b = 0, busy_cnt_b = 0;
  logic [31:0] last_b = '0;
  logic        done_prev_b = 1'b0;
  always @(negedge clk) begin
    if (bus_b.mem_read) begin
      rd_cnt_b++;
      last_b = bus_b.mem_address;
      if (addr_q_b.size() == 0) cmp("b_unexpected_read", bus_b.mem_address, 32'hFFFF_FFFF);
      else cmp("b_addr", bus_b.mem_address, addr_q_b.pop_front());
    end
    if (busy_b) busy_cnt_b++;
    if (done_b && !done_prev_b) begin
      if (res_q_b.size() == 0) cmp("b_unexpected_done", 32'd1, 32'd0);
      else check_res("b", res_q_b.pop_front(), pass_b, tmo_b, err_b, fea_b, fed_b,
                     rd_cnt_b, busy_cnt_b, last_b);
      rd_cnt_b = 0; busy_cnt_b = 0; last_b = '0;
    end
    if (reset_b) begin
      rd_cnt_b = 0; busy_cnt_b = 0; last_b = '0;
    end
    done_prev_b = done_b;
  end

  task automatic push_res(input bit sel, input logic p, input logic t, input logic [15:0] e,
                          input logic [31:0] fa, input logic [31:0] fd, input int rd,
                          input int busy, input logic [31:0] last);
    res_t r;
    r.p = p; r.t = t; r.e = e; r.fa = fa; r.fd = fd; r.rd = rd; r.busy = busy; r.last = last;
    if (sel) res_q_b.push_back(r);
    else res_q_a.push_back(r);
  endtask

  task automatic push_addrs(input bit sel, input logic [31:0] base, input int n, input int rep);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < rep; k++)
        if (sel) addr_q_b.push_back(base + 32'(4 * i));
        else addr_q_a.push_back(base + 32'(4 * i));
  endtask

  // Preload RAM with the arithmetic progression; A's RAM holds byte-reversed words.
  task automatic fill(input bit sel, input logic [31:0] base, input int n,
                      input logic [31:0] es, input logic [31:0] st);
    logic [31:0] a, v;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      v = es + 32'(i) * st;
      if (sel) ram_b[a[9:2]] = v;
      else ram_a[a[9:2]] = bswap(v);
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge clk); #1;
      seen = sel ? done_b : done_a;
    end
    cmp(sel ? "b_done_seen" : "a_done_seen", seen, 1'b1);
    @(negedge clk); #1;
  endtask

  task automatic check_idle_a(input string tag);
    cmp({tag, "_mem_read"}, bus_a.mem_read, 1'b0);
    cmp({tag, "_mem_address"}, bus_a.mem_address, 32'd0);
    cmp({tag, "_busy"}, busy_a, 1'b0);
    cmp({tag, "_done"}, done_a, 1'b0);
    cmp({tag, "_pass"}, pass_a, 1'b0);
    cmp({tag, "_timeout"}, tmo_a, 1'b0);
    cmp({tag, "_errcnt"}, err_a, 16'd0);
    cmp({tag, "_first_addr"}, fea_a, 32'd0);
    cmp({tag, "_first_data"}, fed_a, 32'd0);
  endtask

  task automatic cfg_std_a();
    base_a = {32'h0000_0300, 32'h0000_0100};
    cnt_a  = {16'd29, 16'd29};
    es_a   = {32'hBFC0_0080, 32'hFFFF_FFFF};
    st_a   = {32'h0000_0010, 32'h0000_0000};
  endtask

  task automatic push_std_addrs_a();
    push_addrs(1'b0, 32'h100, 29, 1);
    push_addrs(1'b0, 32'h300, 29, 1);
  endtask

  initial begin
    reset_a = 1'b1; start_a = 1'b0; cpu_a = 1'b1;
    reset_b = 1'b1; start_b = 1'b0; cpu_b = 1'b1;
    base_a = '0; cnt_a = '0; es_a = '0; st_a = '0;
    base_b = '0; cnt_b = '0; es_b = '0; st_b = '0;
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle_a("a_reset");
    cmp("b_reset_busy", busy_b, 1'b0);
    cmp("b_reset_mem_read", bus_b.mem_read, 1'b0);
    reset_a = 1'b0; reset_b = 1'b0;

    // Pass path; CPU goes idle 50 cycles after start.
    cfg_std_a();
    fill(1'b0, 32'h100, 29, 32'hFFFF_FFFF, 32'h0);
    fill(1'b0, 32'h300, 29, 32'hBFC0_0080, 32'h10);
    push_std_addrs_a();
    push_res(1'b0, 1'b1, 1'b0, 16'd0, 32'h0, 32'h0, 58, 108, 32'h370);
    pulse_start(1'b0);
    repeat (49) @(posedge clk);
    #1 cpu_a = 1'b0;
    wait_done(1'b0, 200);

    // Single mismatch in region 1.
    ram_a[8'(32'h308 >> 2)] = bswap(32'h1234_5678);
    push_std_addrs_a();
    push_res(1'b0, 1'b0, 1'b0, 16'd1, 32'h308, 32'h1234_5678, 58, 59, 32'h370);
    pulse_start(1'b0);
    wait_done(1'b0, 200);

    // Second mismatch in region 0 becomes the first reported.
    ram_a[8'(32'h104 >> 2)] = bswap(32'hDEAD_BEEF);
    push_std_addrs_a();
    push_res(1'b0, 1'b0, 1'b0, 16'd2, 32'h104, 32'hDEAD_BEEF, 58, 59, 32'h370);
    pulse_start(1'b0);
    wait_done(1'b0, 200);

    // Reset while word 10 is on the bus (an error has already been captured).
    push_addrs(1'b0, 32'h100, 11, 1);
    pulse_start(1'b0);
    repeat (11) @(posedge clk);
    #1 reset_a = 1'b1;
    @(posedge clk); #1;
    check_idle_a("a_midreset");
    reset_a = 1'b0;

    // Restart on clean RAM; cfg changes after start must not matter.
    fill(1'b0, 32'h100, 29, 32'hFFFF_FFFF, 32'h0);
    fill(1'b0, 32'h300, 29, 32'hBFC0_0080, 32'h10);
    push_std_addrs_a();
    push_res(1'b0, 1'b1, 1'b0, 16'd0, 32'h0, 32'h0, 58, 59, 32'h370);
    pulse_start(1'b0);
    cnt_a = {16'd3, 16'd0};
    base_a = '0;
    wait_done(1'b0, 200);
    cfg_std_a();

    // Endianness: raw 0x8000C0BF swaps to 0xBFC00080; region 1 empty.
    base_a = {32'h0000_0300, 32'h0000_0200};
    cnt_a  = {16'd0, 16'd1};
    es_a   = {32'h0, 32'hBFC0_0080};
    st_a   = '0;
    ram_a[8'(32'h200 >> 2)] = 32'h8000_C0BF;
    push_addrs(1'b0, 32'h200, 1, 1);
    push_res(1'b0, 1'b1, 1'b0, 16'd0, 32'h0, 32'h0, 1, 2, 32'h200);
    pulse_start(1'b0);
    wait_done(1'b0, 50);

    // Timeout: CPU never goes idle.
    cpu_a = 1'b1;
    push_res(1'b0, 1'b0, 1'b1, 16'd0, 32'h0, 32'h0, 0, 100, 32'h0);
    pulse_start(1'b0);
    wait_done(1'b0, 300);
    cpu_a = 1'b0;

    // Registered RAM: region 0 empty, region 1 four words, each address held two cycles.
    base_b = {32'h0000_0300, 32'h0000_0100};
    cnt_b  = {16'd4, 16'd0};
    es_b   = {32'hBFC0_0080, 32'h0};
    st_b   = {32'h0000_0010, 32'h0};
    fill(1'b1, 32'h300, 4, 32'hBFC0_0080, 32'h10);
    cpu_b = 1'b0;
    push_addrs(1'b1, 32'h300, 4, 2);
    push_res(1'b1, 1'b1, 1'b0, 16'd0, 32'h0, 32'h0, 8, 9, 32'h30C);
    pulse_start(1'b1);
    wait_done(1'b1, 100);

    // No swap: raw 0x8000C0BF no longer matches 0xBFC00080.
    base_b = {32'h0000_0300, 32'h0000_0200};
    cnt_b  = {16'd0, 16'd1};
    es_b   = {32'h0, 32'hBFC0_0080};
    st_b   = '0;
    ram_b[8'(32'h200 >> 2)] = 32'h8000_C0BF;
    push_addrs(1'b1, 32'h200, 1, 2);
    push_res(1'b1, 1'b0, 1'b0, 16'd1, 32'h200, 32'h8000_C0BF, 2, 3, 32'h200);
    pulse_start(1'b1);
    wait_done(1'b1, 50);

    repeat (4) @(posedge clk);
    #1;
    cmp("a_addr_queue_drained", addr_q_a.size(), 0);
    cmp("a_res_queue_drained", res_q_a.size(), 0);
    cmp("b_addr_queue_drained", addr_q_b.size(), 0);
    cmp("b_res_queue_drained", res_q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
